// File: rtl/fetch_sequencer.sv
// Instruction fetch: owns the PC, issues one req/ack read per instruction, holds it for decode.
// Latency: ack in the first FETCH cycle gives instr_valid next cycle; decode backpressure holds DELIVER, redirects kill.
module fetch_sequencer #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic [15:0]       instr_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DELIVER,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [15:0]       instr_count_q, instr_count_d;
  logic              redir_pend_q, redir_pend_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_pc_q    <= '0;
      redir_pc_q    <= '0;
      instr_q       <= '0;
      instr_count_q <= '0;
      redir_pend_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_pc_q    <= instr_pc_d;
      redir_pc_q    <= redir_pc_d;
      instr_q       <= instr_d;
      instr_count_q <= instr_count_d;
      redir_pend_q  <= redir_pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_pc_d    = instr_pc_q;
    redir_pc_d    = redir_pc_q;
    instr_d       = instr_q;
    instr_count_d = instr_count_q;
    redir_pend_d  = redir_pend_q;

    mem_req     = (state_q == S_FETCH);
    instr_valid = (state_q == S_DELIVER) && !redirect;
    halted      = (state_q == S_HALT);

    unique case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (run) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // The request address is frozen until ack; a redirect seen mid-request is parked
        // and the returning data is dropped in favour of the newest target.
        if (mem_ack) begin
          if (redirect || redir_pend_q) begin
            pc_d         = redirect ? redirect_pc : redir_pc_q;
            redir_pend_d = 1'b0;
          end else begin
            instr_d    = mem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 1'b1;
            state_d    = S_DELIVER;
          end
        end else if (redirect) begin
          redir_pend_d = 1'b1;
          redir_pc_d   = redirect_pc;
        end
      end
      S_DELIVER: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end else if (instr_ready) begin
          instr_count_d = instr_count_q + 16'd1;
          if (instr_q[DATA_W-1 -: 4] == HALT_OP) begin
            state_d = S_HALT;
          end else if (run) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_addr    = pc_q;
  assign pc_out      = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: the reference is the program-order stream of words
// starting at the last redirect target; a monitor pops it on every decode transfer.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        mem_req, mem_ack = 1'b0;
  logic [15:0] mem_addr, mem_rdata = 16'h0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [15:0] instr, instr_pc, pc_out, instr_count;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        halted;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000), .HALT_OP(4'hF)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .pc_out(pc_out), .halted(halted), .instr_count(instr_count)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- memory image ----------------
  logic [15:0] mem_ovr [logic [15:0]];

  function automatic logic [15:0] mem_word(logic [15:0] a);
    logic [15:0] h;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    h = a * 16'h9E37 + 16'h1234;
    return {1'b0, h[14:0]};
  endfunction

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_count = 16'h0;
  bit          model_halted = 1'b0;
  int          deliveries = 0;
  int          cyc = 0;
  int          last_del_cyc = -1;
  int          gap_check = 0;

  function automatic void model_reset();
    exp_q.delete();
    exp_q.push_back('{pc: 16'h0000, ins: mem_word(16'h0000)});
    model_count  = 16'h0;
    model_halted = 1'b0;
  endfunction

  function automatic void model_redirect(logic [15:0] t);
    if (!model_halted) begin
      exp_q.delete();
      exp_q.push_back('{pc: t, ins: mem_word(t)});
    end
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] np;
    if (!reset) begin
      if (redirect) check("kill_on_redirect", {31'b0, instr_valid}, 32'd0);
      if (instr_valid && instr_ready) begin
        deliveries++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got pc %h instr %h expected none", instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", {16'b0, instr_pc}, {16'b0, e.pc});
          check("deliver_instr", {16'b0, instr}, {16'b0, e.ins});
          check("deliver_count", {16'b0, instr_count}, {16'b0, model_count});
          if (e.ins[15:12] == 4'hF) begin
            model_halted = 1'b1;
          end else begin
            np = e.pc + 16'd1;
            exp_q.push_back('{pc: np, ins: mem_word(np)});
          end
        end
        model_count = model_count + 16'd1;
        if (gap_check > 0 && last_del_cyc >= 0) check("delivery_gap", cyc - last_del_cyc, gap_check);
        last_del_cyc = cyc;
      end
    end
  end

  // ---------------- memory responder ----------------
  int          mem_wait_fixed = -1;
  bit          mem_busy = 1'b0;
  bit          late_ack = 1'b0;
  int          wcnt = 0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_log[$];

  always @(negedge clk) begin
    if (reset || !mem_req) begin
      mem_busy  = 1'b0;
      mem_ack   = late_ack;
      mem_rdata = 16'hDEAD;
    end else begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        req_addr = mem_addr;
        req_log.push_back(mem_addr);
        wcnt = (mem_wait_fixed >= 0) ? mem_wait_fixed : int'($urandom_range(0, 3));
      end else begin
        check("mem_addr_stable", {16'b0, mem_addr}, {16'b0, req_addr});
      end
      if (wcnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(req_addr);
        mem_busy  = 1'b0;
      end else begin
        wcnt--;
        mem_ack = 1'b0;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; run = 1'b0; redirect = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_deliveries(int target, string tag);
    int n = 0;
    while (deliveries < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (deliveries < target) begin
      errors++;
      $display("FAIL timeout_%s: deliveries %0d expected %0d", tag, deliveries, target);
    end
  endtask

  task automatic wait_valid(bit check_pc, string tag);
    int n = 0;
    @(negedge clk);
    while (!instr_valid && n < 100) begin
      if (check_pc && mem_req && exp_q.size() > 0) check("pc_hold_in_fetch", {16'b0, pc_out}, {16'b0, exp_q[0].pc});
      @(negedge clk);
      n++;
    end
    checks++;
    if (!instr_valid) begin
      errors++;
      $display("FAIL timeout_%s: instr_valid %b expected 1", tag, instr_valid);
    end
  endtask

  task automatic wait_new_req(int base, string tag);
    int n = 0;
    while (req_log.size() <= base && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (req_log.size() <= base) begin
      errors++;
      $display("FAIL timeout_%s: requests %0d expected more than %0d", tag, req_log.size(), base);
    end
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          base;
    logic [15:0] cnt_before;

    mem_ovr[16'h0000] = 16'h1111;
    mem_ovr[16'h0001] = 16'h2222;
    mem_ovr[16'h0002] = 16'h3333;
    mem_ovr[16'h0003] = 16'h4444;
    mem_ovr[16'h0300] = 16'hF000;

    do_reset();
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_pc", {16'b0, pc_out}, 32'h0);
    check("rst_instr", {16'b0, instr}, 32'h0);
    check("rst_instr_pc", {16'b0, instr_pc}, 32'h0);
    check("rst_count", {16'b0, instr_count}, 32'h0);

    // Zero-wait memory, decode always ready: back-to-back deliveries.
    req_log.delete();
    mem_wait_fixed = 0;
    instr_ready = 1'b1;
    gap_check = 2;
    last_del_cyc = -1;
    run = 1'b1;
    wait_deliveries(4, "seq4");
    check("seq_count4", {16'b0, instr_count}, 32'd4);
    for (int i = 0; i < 4; i++) check("seq_req_addr", {16'b0, req_log[i]}, i);
    gap_check = 0;

    // Slow memory plus decode stalls: data and pc must hold.
    mem_wait_fixed = 3;
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_valid(1'b1, "stall_valid");
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        check("stall_valid_held", {31'b0, instr_valid}, 32'd1);
        check("stall_instr_held", {16'b0, instr}, {16'b0, exp_q[0].ins});
        check("stall_pc_held", {16'b0, instr_pc}, {16'b0, exp_q[0].pc});
      end
      @(posedge clk); #1; instr_ready = 1'b1;
      @(posedge clk); #1; instr_ready = 1'b0;
    end

    // Redirect while an instruction waits in DELIVER with ready high.
    wait_valid(1'b0, "redir_deliver");
    @(posedge clk); #1;
    cnt_before = model_count;
    instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 16'h00A0;
    model_redirect(16'h00A0);
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    check("redir_dlv_req", {31'b0, mem_req}, 32'd1);
    check("redir_dlv_addr", {16'b0, mem_addr}, 32'h00A0);
    check("redir_dlv_count", {16'b0, instr_count}, {16'b0, cnt_before});
    wait_deliveries(deliveries + 1, "after_a0");

    // Redirect two cycles before the ack of an outstanding request.
    instr_ready = 1'b0;
    mem_wait_fixed = 4;
    wait_valid(1'b0, "redir_fetch_setup");
    base = req_log.size();
    @(posedge clk); #1; instr_ready = 1'b1;
    wait_new_req(base, "redir_fetch_req");
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 16'h0040;
    model_redirect(16'h0040);
    @(posedge clk); #1;
    redirect = 1'b0;
    wait_new_req(base + 1, "redir_fetch_next");
    check("redir_fetch_next_addr", {16'b0, req_log[base + 1]}, 32'h0040);
    wait_deliveries(deliveries + 1, "after_40");

    // Address wrap through 16'hFFFF.
    mem_wait_fixed = -1;
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    model_redirect(16'hFFFF);
    @(posedge clk); #1;
    redirect = 1'b0;
    wait_deliveries(deliveries + 2, "wrap");
    check("wrap_req_ffff", {16'b0, req_log[req_log.size() - 2]}, 32'hFFFF);
    check("wrap_req_0000", {16'b0, req_log[req_log.size() - 1]}, 32'h0000);

    // HALT opcode stops fetch until reset.
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 16'h0300;
    model_redirect(16'h0300);
    @(posedge clk); #1;
    redirect = 1'b0;
    wait_deliveries(deliveries + 1, "halt_fetch");
    check("halt_model_flag", {31'b0, model_halted}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      run = 1'b1;
      redirect = i[0]; redirect_pc = 16'h0010;
      model_redirect(16'h0010);
      @(negedge clk);
      check("halt_halted", {31'b0, halted}, 32'd1);
      check("halt_no_req", {31'b0, mem_req}, 32'd0);
      check("halt_no_valid", {31'b0, instr_valid}, 32'd0);
      @(posedge clk); #1;
    end
    redirect = 1'b0;
    do_reset();
    check("halt_rst_pc", {16'b0, pc_out}, 32'h0);
    check("halt_rst_halted", {31'b0, halted}, 32'd0);
    @(negedge clk);
    check("halt_rst_idle", {31'b0, mem_req}, 32'd0);
    mem_ovr.delete(16'h0300);

    // Reset while a request is outstanding, then a stray ack in IDLE.
    mem_wait_fixed = 10;
    instr_ready = 1'b1;
    base = req_log.size();
    @(posedge clk); #1; run = 1'b1;
    wait_new_req(base, "rst_mid_req");
    check("rst_mid_req_high", {31'b0, mem_req}, 32'd1);
    do_reset();
    check("rst_mid_req", {31'b0, mem_req}, 32'd0);
    check("rst_mid_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_mid_pc", {16'b0, pc_out}, 32'h0);
    late_ack = 1'b1;
    @(posedge clk); #1; late_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req", {31'b0, mem_req}, 32'd0);
    check("late_ack_valid", {31'b0, instr_valid}, 32'd0);
    check("late_ack_pc", {16'b0, pc_out}, 32'h0);
    check("late_ack_count", {16'b0, instr_count}, 32'h0);
    mem_wait_fixed = 0;
    @(posedge clk); #1; run = 1'b1;
    wait_deliveries(deliveries + 2, "after_late_ack");

    // Randomized traffic: run, ready, redirects and memory latency all vary.
    mem_wait_fixed = -1;
    base = deliveries;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      run = ($urandom_range(0, 9) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = 16'($urandom);
      if (redirect) model_redirect(redirect_pc);
    end
    @(posedge clk); #1;
    redirect = 1'b0;
    check("random_progress", {31'b0, (deliveries - base) > 100}, 32'd1);
    @(negedge clk);
    check("final_count", {16'b0, instr_count}, {16'b0, model_count});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that owns the program counter and sequences each fetch. It issues a req/ack memory read at the PC, holds the fetched word for decode on a valid/ready handshake, and advances the PC by one word per instruction. It also applies branch/jump redirects from execute and stops on a HALT opcode. It sits between instruction memory and the decode stage of the 16-bit core.

Parameters:
ADDR_W, 16, PC and memory address width
DATA_W, 16, instruction width
RESET_PC, 16'h0000, PC value after reset
HALT_OP, 4'hF, opcode in instr[DATA_W-1:DATA_W-4] that halts fetch

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  fetch enable; sampled in IDLE and at each delivery
mem_req  output  1  memory read request
mem_addr  output  ADDR_W  read address, equals pc
mem_ack  input  1  read complete; mem_rdata valid this cycle
mem_rdata  input  DATA_W  read data
instr_valid  output  1  fetched instruction available to decode
instr  output  DATA_W  fetched instruction (registered)
instr_pc  output  ADDR_W  address instr was fetched from (registered)
instr_ready  input  1  decode accepts instr
redirect  input  1  load new PC (branch/jump taken)
redirect_pc  input  ADDR_W  redirect target
pc_out  output  ADDR_W  current PC (next fetch address)
halted  output  1  high in HALT state
instr_count  output  16  number of instructions delivered (valid&ready), wraps

Behaviour:
- Reset (synchronous, priority over all inputs, including mid-fetch): state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_count=0, redir_pend=0. Outputs mem_req=0, instr_valid=0, halted=0.
- Decoded outputs: mem_req=(state==FETCH), mem_addr=pc_out=pc, instr_valid=(state==DELIVER)&&!redirect, halted=(state==HALT).
- IDLE:
  - redirect → pc<=redirect_pc, stay IDLE.
  - else if run → FETCH next cycle.
- FETCH: mem_req high; mem_addr holds constant until mem_ack.
  - redirect without ack → set redir_pend, latch redir_pc<=redirect_pc. A later redirect overwrites redir_pc. mem_addr stays unchanged.
  - mem_ack with redirect or redir_pend → discard mem_rdata. pc<=redirect_pc if redirect is high this cycle, else redir_pc. Clear redir_pend, stay FETCH; the new request is issued next cycle.
  - mem_ack otherwise → instr<=mem_rdata, instr_pc<=pc, pc<=pc+1 modulo 2^ADDR_W (16'hFFFF→16'h0000), go to DELIVER.
  - Minimum fetch latency: ack in the first FETCH cycle gives instr_valid on the next cycle.
- DELIVER:
  - redirect → instruction is killed (instr_valid forced low combinationally, no transfer, instr_count unchanged), pc<=redirect_pc, go to FETCH.
  - instr_valid&&instr_ready → instr_count+1.
    - If instr opcode == HALT_OP → HALT.
    - Else if run → FETCH.
    - Else → IDLE.
  - No ready → hold; instr and instr_pc are stable.
- HALT: no requests; redirect and run are ignored; exit only via reset.
- run dropping during FETCH does not abort the outstanding request.
- instr_count wraps 16'hFFFF→0.

Test Plan:
- Reset then run=1, memory acks every request with 0-cycle wait, decode always ready, mem[0..3]=16'h1111,2222,3333,4444 → mem_addr 0,1,2,3 in order; instr_pc 0,1,2,3 with matching instr; one delivery every 2 cycles; instr_count=4.
- Ack delayed 3 cycles and instr_ready low 2 cycles in DELIVER → mem_addr stable during the wait; instr/instr_valid held; pc advances only on ack; no duplicate or lost instruction.
- Redirect to 16'h00A0 in DELIVER with instr_ready=1 → no transfer that cycle, instr_count unchanged; next mem_addr=16'h00A0. Redirect to 16'h0040 in FETCH two cycles before ack → that ack's data discarded; next request at 16'h0040.
- redirect_pc=16'hFFFF then fetch → instr_pc=16'hFFFF and next mem_addr=16'h0000.
- Fetch 16'hF000 → after transfer halted=1, mem_req stays 0 for 20 cycles despite run and redirect; reset → pc=0, halted=0, state IDLE.
- Reset asserted while mem_req high and ack pending → next cycle mem_req=0, instr_valid=0, pc=RESET_PC; the late ack arriving in IDLE is ignored.
